// File: rtl/oam_dma_arbiter.sv
// Sprite-DMA controller and CPU bus arbiter: passes CPU traffic through until a write to
// DMA_REG_ADDR, then stalls the CPU and copies one page to the OAM data port.
// Optional macro OAM_DMA_PERF_EN adds the dma_done / dma_cycles performance outputs.
module oam_dma_arbiter #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter int          XFER_LEN      = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_d_out,
  input  logic        cpu_we,
  output logic        cpu_rdy,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_d_out,
  output logic        bus_we,
  input  logic [7:0]  bus_d_in
`ifdef OAM_DMA_PERF_EN
  ,
  output logic        dma_done,
  output logic [9:0]  dma_cycles
`endif
);

  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  state_t     state, state_next;
  logic       cyc_odd;
  logic [7:0] idx;
  logic [7:0] page;
  logic [7:0] latch;
  logic       trigger;
  logic       last_write;

  // Only a write seen while idle starts a transfer; later strobes are stale CPU state.
  assign trigger    = (state == IDLE) && cpu_we && (cpu_addr == DMA_REG_ADDR);
  assign last_write = (state == WRITE) && (idx == LAST_IDX);
  assign cpu_rdy    = (state == IDLE);

  always_comb begin
    state_next = state;
    bus_addr   = cpu_addr;
    bus_d_out  = cpu_d_out;
    bus_we     = 1'b0;
    case (state)
      IDLE: begin
        bus_we = cpu_we;
        if (trigger) state_next = HALT;
      end
      // The following cycle has the opposite parity; reads must land on even cycles.
      HALT:  state_next = cyc_odd ? READ : ALIGN;
      ALIGN: state_next = READ;
      READ: begin
        bus_addr   = {page, idx};
        state_next = WRITE;
      end
      WRITE: begin
        bus_addr   = OAM_DATA_ADDR;
        bus_d_out  = latch;
        bus_we     = 1'b1;
        state_next = (idx == LAST_IDX) ? IDLE : READ;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cyc_odd <= 1'b0;
      idx     <= 8'd0;
      page    <= 8'd0;
      latch   <= 8'd0;
    end else begin
      state   <= state_next;
      cyc_odd <= ~cyc_odd;
      if (trigger) begin
        page <= cpu_d_out;
        idx  <= 8'd0;
      end
      if (state == READ) latch <= bus_d_in;
      if (state == WRITE) idx <= (idx == LAST_IDX) ? 8'd0 : idx + 8'd1;
    end
  end

`ifdef OAM_DMA_PERF_EN
  logic [9:0] stall_cnt;

  // stall_cnt counts the stalled cycles so far; the final write cycle is added on capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      dma_done   <= 1'b0;
      dma_cycles <= 10'd0;
      stall_cnt  <= 10'd0;
    end else begin
      dma_done <= last_write;
      if (last_write) begin
        dma_cycles <= stall_cnt + 10'd1;
        stall_cnt  <= 10'd0;
      end else if (state != IDLE) begin
        stall_cnt <= stall_cnt + 10'd1;
      end else begin
        stall_cnt <= 10'd0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Scoreboard bench for oam_dma_arbiter: expected bus events are queued at each trigger
// and compared against events captured from the bus while the CPU is stalled.
module tb_oam_dma_arbiter;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        odd;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_d_out;
  logic        cpu_we;
  logic        cpu_rdy;
  logic [15:0] bus_addr;
  logic [7:0]  bus_d_out;
  logic        bus_we;
  logic [7:0]  bus_d_in;
`ifdef OAM_DMA_PERF_EN
  logic        dma_done;
  logic [9:0]  dma_cycles;
`endif

  int   tests = 0;
  int   fails = 0;
  int   stall_cnt = 0;
  int   done_cnt = 0;
  logic tb_odd = 1'b0;
  ev_t  exp_q[$];
  ev_t  obs_q[$];

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_val(input logic [15:0] a);
    return a[7:0] ^ 8'hA5 ^ (a[15:8] - 8'h02);
  endfunction

  assign bus_d_in = mem_val(bus_addr);

  oam_dma_arbiter dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_d_out(cpu_d_out), .cpu_we(cpu_we),
    .cpu_rdy(cpu_rdy), .bus_addr(bus_addr), .bus_d_out(bus_d_out), .bus_we(bus_we),
    .bus_d_in(bus_d_in)
`ifdef OAM_DMA_PERF_EN
    , .dma_done(dma_done), .dma_cycles(dma_cycles)
`endif
  );

  always @(posedge clk) tb_odd <= rst ? 1'b0 : ~tb_odd;

  // Capture DMA reads (addresses differing from the stalled CPU) and every stalled write.
  always @(negedge clk) begin
    if (!rst && cpu_rdy === 1'b0) begin
      stall_cnt++;
      if (bus_we !== 1'b0) obs_q.push_back(ev_t'{1'b1, bus_addr, bus_d_out, tb_odd});
      else if (bus_addr !== cpu_addr) obs_q.push_back(ev_t'{1'b0, bus_addr, 8'h00, tb_odd});
    end
`ifdef OAM_DMA_PERF_EN
    if (dma_done === 1'b1) done_cnt++;
`endif
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic start_dma(input logic [7:0] pg, input logic want_odd);
    while (tb_odd !== want_odd) step();
    exp_q.delete();
    obs_q.delete();
    stall_cnt = 0;
    done_cnt  = 0;
    for (int i = 0; i < 256; i++) begin
      exp_q.push_back(ev_t'{1'b0, {pg, 8'(i)}, 8'h00, 1'b0});
      exp_q.push_back(ev_t'{1'b1, 16'h2004, mem_val({pg, 8'(i)}), 1'b1});
    end
    cpu_addr  = 16'h4014;
    cpu_d_out = pg;
    cpu_we    = 1'b1;
    step();
    cpu_we    = 1'b0;
    cpu_d_out = 8'h00;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 700; n++) begin
      if (cpu_rdy === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    tests++;
    if (cpu_rdy !== 1'b1) begin fails++; $display("[TB] FAIL reset_rdy got %b want 1", cpu_rdy); end
    tests++;
    if (bus_we !== 1'b0) begin fails++; $display("[TB] FAIL reset_bus_we got %b want 0", bus_we); end
`ifdef OAM_DMA_PERF_EN
    tests++;
    if (dma_cycles !== 10'd0 || dma_done !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_perf got cycles=%0d done=%b want 0/0", dma_cycles, dma_done);
    end
`endif
    rst = 1'b1; cpu_addr = 16'h4014; cpu_d_out = 8'h33; cpu_we = 1'b1;
    step();
    rst = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000;
    tests++;
    if (cpu_rdy !== 1'b1) begin fails++; $display("[TB] FAIL rst_beats_trigger got rdy=%b want 1", cpu_rdy); end
    step();
    tests++;
    if (cpu_rdy !== 1'b1) begin fails++; $display("[TB] FAIL rst_beats_trigger_next got rdy=%b want 1", cpu_rdy); end
  endtask

  task automatic test_passthrough();
    cpu_addr = 16'h8000; cpu_d_out = 8'h11; cpu_we = 1'b0;
    step();
    tests++;
    if (bus_addr !== 16'h8000 || bus_we !== 1'b0 || cpu_rdy !== 1'b1) begin
      fails++; $display("[TB] FAIL pass_read got addr=%h we=%b rdy=%b want 8000/0/1", bus_addr, bus_we, cpu_rdy);
    end
    cpu_addr = 16'h0300; cpu_d_out = 8'h5A; cpu_we = 1'b1;
    step();
    tests++;
    if (bus_addr !== 16'h0300 || bus_d_out !== 8'h5A || bus_we !== 1'b1 || cpu_rdy !== 1'b1) begin
      fails++; $display("[TB] FAIL pass_write got addr=%h d=%h we=%b rdy=%b want 0300/5a/1/1",
                        bus_addr, bus_d_out, bus_we, cpu_rdy);
    end
    cpu_we = 1'b0;
    step();
  endtask

  task automatic test_trigger_parity();
    bit ok;
    for (int p = 0; p < 2; p++) begin
      start_dma(8'h02, p[0]);
      wait_idle(ok);
      tests++;
      if (!ok) begin fails++; $display("[TB] FAIL parity%0d_timeout cpu_rdy never returned", p); end
      tests++;
      if (stall_cnt !== 513 + p) begin
        fails++; $display("[TB] FAIL parity%0d_stall got %0d want %0d", p, stall_cnt, 513 + p);
      end
      tests++;
      if (obs_q.size() !== exp_q.size()) begin
        fails++; $display("[TB] FAIL parity%0d_events got %0d want %0d", p, obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) begin
        tests++;
        if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
          fails++; $display("[TB] FAIL parity%0d_event%0d got %h want %h", p, i,
                            (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
        end
      end
`ifdef OAM_DMA_PERF_EN
      tests++;
      if (dma_cycles !== 10'(513 + p) || done_cnt !== 1) begin
        fails++; $display("[TB] FAIL parity%0d_perf got cycles=%0d done=%0d want %0d/1",
                          p, dma_cycles, done_cnt, 513 + p);
      end
`endif
    end
  endtask

  task automatic test_page_ff();
    bit ok;
    start_dma(8'hFF, 1'b0);
    wait_idle(ok);
    tests++;
    if (!ok) begin fails++; $display("[TB] FAIL pageff_timeout cpu_rdy never returned"); end
    tests++;
    if (obs_q.size() !== exp_q.size()) begin
      fails++; $display("[TB] FAIL pageff_events got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      tests++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        fails++; $display("[TB] FAIL pageff_event%0d got %h want %h", i,
                          (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_abort();
    bit ok;
    int n;
    start_dma(8'h02, 1'b0);
    n = 0;
    while (obs_q.size() < 201 && n < 600) begin step(); n++; end
    tests++;
    if (obs_q.size() !== 201) begin fails++; $display("[TB] FAIL abort_reach got %0d events want 201", obs_q.size()); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++;
    if (cpu_rdy !== 1'b1) begin fails++; $display("[TB] FAIL abort_rdy got %b want 1", cpu_rdy); end
    for (int k = 0; k < 20; k++) step();
    tests++;
    if (obs_q.size() !== 201) begin fails++; $display("[TB] FAIL abort_quiet got %0d events want 201", obs_q.size()); end
    for (int i = 0; i < 201; i++) begin
      tests++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        fails++; $display("[TB] FAIL abort_event%0d got %h want %h", i,
                          (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
      end
    end
`ifdef OAM_DMA_PERF_EN
    tests++;
    if (done_cnt !== 0) begin fails++; $display("[TB] FAIL abort_done got %0d pulses want 0", done_cnt); end
`endif
    start_dma(8'h02, 1'b0);
    wait_idle(ok);
    tests++;
    if (!ok || obs_q.size() !== exp_q.size()) begin
      fails++; $display("[TB] FAIL restart_events got %0d ok=%b want %0d", obs_q.size(), ok, exp_q.size());
    end
    foreach (exp_q[i]) begin
      tests++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        fails++; $display("[TB] FAIL restart_event%0d got %h want %h", i,
                          (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
      end
    end
  endtask

  task automatic test_retrigger();
    bit ok;
    start_dma(8'h02, 1'b1);
    for (int k = 0; k < 8; k++) begin
      cpu_addr = 16'h4014; cpu_d_out = 8'h07; cpu_we = 1'b1;
      step();
    end
    cpu_we = 1'b0; cpu_d_out = 8'h00;
    wait_idle(ok);
    tests++;
    if (!ok || stall_cnt !== 514) begin
      fails++; $display("[TB] FAIL retrig_stall got %0d ok=%b want 514", stall_cnt, ok);
    end
    tests++;
    if (obs_q.size() !== exp_q.size()) begin
      fails++; $display("[TB] FAIL retrig_events got %0d want %0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      tests++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        fails++; $display("[TB] FAIL retrig_event%0d got %h want %h", i,
                          (i < obs_q.size()) ? obs_q[i] : '0, exp_q[i]);
      end
    end
  endtask

  initial begin
    rst = 1'b1; cpu_addr = 16'h0000; cpu_d_out = 8'h00; cpu_we = 1'b0;
    step();
    test_reset();
    test_passthrough();
    test_trigger_parity();
    test_page_ff();
    test_reset_abort();
    test_retrigger();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/oam_dma_arbiter.md
Name: oam_dma_arbiter

Overview:
- Sprite-DMA controller and bus arbiter placed between the cpu core and the shared CPU memory bus.
- Normally passes CPU bus traffic straight through.
- A CPU write to the DMA register halts the CPU through cpu_rdy. The block then takes the bus and copies one 256-byte page from CPU memory to the PPU OAM data port as alternating read and write cycles.
- When the copy finishes it returns the bus to the CPU.

Parameters:
- DMA_REG_ADDR, 16'h4014, write to this address with data P starts a DMA from page P
- OAM_DATA_ADDR, 16'h2004, destination address for every DMA write
- XFER_LEN, 256, bytes per DMA; must be a power of two no greater than 256

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- cpu_addr  input  16  CPU address
- cpu_d_out  input  8  CPU write data
- cpu_we  input  1  CPU write strobe
- cpu_rdy  output  1  1 = CPU may advance; 0 = CPU must stall (hold its state)
- bus_addr  output  16  address to memory bus
- bus_d_out  output  8  write data to memory bus
- bus_we  output  1  write strobe to memory bus
- bus_d_in  input  8  read data from memory bus, valid in the same cycle as bus_addr

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is synchronous and active-high (rst); it is sampled only on the posedge of clk.
  - Reset values: state=IDLE, cyc_odd=0, idx=0, page=0, latch=0, cpu_rdy=1.
- Parity:
  - Register cyc_odd toggles every cycle.
  - DMA reads occur only on cycles with cyc_odd=0; DMA writes occur only on cycles with cyc_odd=1.
- States: IDLE, HALT, ALIGN, READ, WRITE.
  - IDLE: bus_addr=cpu_addr, bus_d_out=cpu_d_out, bus_we=cpu_we, cpu_rdy=1.
    - Trigger = cpu_we & (cpu_addr==DMA_REG_ADDR). On a trigger, page<=cpu_d_out, idx<=0, and the next state is HALT.
    - The trigger write itself passes through to the bus.
  - HALT: one cycle. The next state is READ if the following cycle has cyc_odd=0; otherwise it is ALIGN.
  - ALIGN: one cycle; the next state is READ.
  - READ: bus_addr={page,idx}, bus_we=0. latch<=bus_d_in. The next state is WRITE.
  - WRITE: bus_addr=OAM_DATA_ADDR, bus_d_out=latch, bus_we=1.
    - If idx==XFER_LEN-1, the next state is IDLE; otherwise idx<=idx+1 and the next state is READ.
- In every state except IDLE:
  - cpu_rdy=0.
  - The CPU's bus_we is suppressed.
  - In HALT and ALIGN, bus_addr=cpu_addr and bus_we=0.
- cpu_rdy is decoded from the state register alone (state==IDLE), with no combinational path from inputs.
- Timing for a trigger in cycle T:
  - cpu_rdy=0 during T+1 onward.
  - T with cyc_odd=0: the last write is at T+513; 513 stall cycles.
  - T with cyc_odd=1: one ALIGN cycle is inserted; 514 stall cycles.
  - cpu_rdy=1 again in the cycle after the last write.
- idx is 8-bit. The page does not increment; {page,idx} never crosses a page boundary.
- Boundary conditions:
  - A write to DMA_REG_ADDR while not in IDLE is ignored. The CPU is halted, so any such write is a stale strobe; page is not reloaded.
  - Page FF: addresses FF00..FFFF; idx wraps internally to 0 only on return to IDLE.
  - Reset mid-DMA: the next cycle is IDLE with cpu_rdy=1; the partial transfer is abandoned and no further bus writes occur.
  - A trigger in the same cycle as rst: rst wins.

Optional Feature:
- Macro: OAM_DMA_PERF_EN.
- When defined, two extra outputs are added:
  - dma_done (1): a one-cycle pulse in the first IDLE cycle after a completed transfer. It does not fire after a reset abort.
  - dma_cycles (10): the count of stall cycles of the last completed DMA (513 or 514). It holds until the next completion; reset value 0.
- When not defined, these ports and their logic are absent and the core behaviour is unchanged.

Test Plan:
- Pass-through: reset, then CPU read of 8000 and write 0x5A to 0300 -> bus mirrors the CPU each cycle; cpu_rdy stays 1.
- Even trigger: memory 0200..02FF = idx^0xA5; write 0x02 to 4014 on cyc_odd=0 -> 256 writes to 2004 with data idx^0xA5 in order; cpu_rdy low exactly 513 cycles; dma_cycles=513 and dma_done pulses once.
- Odd trigger: same as the even trigger but issued on cyc_odd=1 -> one ALIGN cycle, first read on an even cycle, cpu_rdy low 514 cycles, dma_cycles=514.
- Page FF: write 0xFF to 4014 -> reads FF00..FFFF; no address outside that page.
- Reset abort: assert rst during the READ of idx 100 -> next cycle IDLE, cpu_rdy=1, no further 2004 writes, dma_done not pulsed. A fresh trigger afterwards restarts from idx 0.
- Retrigger: a forced cpu_we at 4014 with data 0x07 mid-DMA -> ignored; the transfer continues from the original page and bus_we stays 0 in HALT and ALIGN.
